div_sign_ctrl: RTL and testbench

Operand conditioner and result collector wrapped around the pipelined unsigned divider `divfunc`. It accepts signed or unsigned XLEN-bit operand pairs on a valid/ready interface and issues the magnitudes to the divider. Quotient and remainder signs are fixed in a sideband pipeline kept in lock-step with the divider. Divide-by-zero is overridden, and results are buffered in an output FIFO so downstream backpressure never stalls the non-stallable divider.

---
 rtl/div_sign_ctrl.sv | 171 +++++++++++++++++
 tb/tb_div_sign_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sign_ctrl.sv
// Signed/unsigned operand conditioning and result collection around the pipelined
// unsigned divider: magnitude issue, lock-step sign sideband, zero-divisor override, output FIFO.
module div_sign_ctrl #(
  parameter int XLEN    = 32,
  parameter int LATENCY = 4,
  parameter int TAGW    = 4,
  parameter int DEPTH   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            in_signed,
  input  logic [TAGW-1:0] in_tag,
  output logic            div_vld,
  output logic [XLEN-1:0] div_a,
  output logic [XLEN-1:0] div_b,
  input  logic [XLEN-1:0] div_quo,
  input  logic [XLEN-1:0] div_rem,
  input  logic            div_ack,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [XLEN-1:0] out_quo,
  output logic [XLEN-1:0] out_rem,
  output logic [TAGW-1:0] out_tag,
  output logic            out_dz,
  output logic            err
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic            v;
    logic            nq;
    logic            nr;
    logic            dz;
    logic [XLEN-1:0] a;
    logic [TAGW-1:0] tag;
  } sb_t;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // in_rdy never depends on in_vld, and out_vld never depends on out_rdy.
  logic          accept, pop;
  logic [CW-1:0] used_q, used_d;

  assign in_rdy = (used_q < CW'(DEPTH));
  assign accept = in_vld & in_rdy;
  assign pop    = out_vld & out_rdy;

  // Credits cover in-flight operations plus FIFO occupancy, so the FIFO cannot overflow.
  always_comb begin
    used_d = used_q;
    if (accept && !pop)      used_d = used_q + CW'(1);
    else if (pop && !accept) used_d = used_q - CW'(1);
  end

  logic            a_neg, b_neg;
  sb_t             iss_d, iss_q;
  logic            div_vld_q;
  logic [XLEN-1:0] div_a_q, div_b_q;

  always_comb begin
    a_neg     = in_signed & in_a[XLEN-1];
    b_neg     = in_signed & in_b[XLEN-1];
    iss_d     = '0;
    iss_d.v   = accept;
    iss_d.nq  = a_neg ^ b_neg;
    iss_d.nr  = a_neg;
    iss_d.dz  = (in_b == '0);
    iss_d.a   = in_a;
    iss_d.tag = in_tag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      used_q    <= '0;
      div_vld_q <= 1'b0;
      div_a_q   <= '0;
      div_b_q   <= '0;
      iss_q     <= '0;
    end else begin
      used_q    <= used_d;
      div_vld_q <= accept;
      iss_q     <= iss_d;
      if (accept) begin
        div_a_q <= a_neg ? -in_a : in_a;
        div_b_q <= b_neg ? -in_b : in_b;
      end
    end
  end

  assign div_vld = div_vld_q;
  assign div_a   = div_a_q;
  assign div_b   = div_b_q;

  // Sideband trails the issue register by one edge so its last entry lines up with div_ack.
  sb_t sb_q [LATENCY+1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= LATENCY; i++) sb_q[i] <= '0;
    end else begin
      sb_q[0] <= iss_q;
      for (int i = 1; i <= LATENCY; i++) sb_q[i] <= sb_q[i-1];
    end
  end

  sb_t             last;
  logic            wr;
  logic [XLEN-1:0] wr_quo, wr_rem;

  always_comb begin
    last   = sb_q[LATENCY];
    wr     = last.v;
    wr_quo = last.dz ? {XLEN{1'b1}} : (last.nq ? -div_quo : div_quo);
    wr_rem = last.dz ? last.a : (last.nr ? -div_rem : div_rem);
  end

  logic [XLEN-1:0] quo_mem [DEPTH];
  logic [XLEN-1:0] rem_mem [DEPTH];
  logic [TAGW-1:0] tag_mem [DEPTH];
  logic            dz_mem  [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q;

  always_comb begin
    cnt_d = cnt_q;
    if (wr && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !wr) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        quo_mem[i] <= '0;
        rem_mem[i] <= '0;
        tag_mem[i] <= '0;
        dz_mem[i]  <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (wr) begin
        quo_mem[wr_ptr_q] <= wr_quo;
        rem_mem[wr_ptr_q] <= wr_rem;
        tag_mem[wr_ptr_q] <= last.tag;
        dz_mem[wr_ptr_q]  <= last.dz;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
        if (!div_ack) err_q <= 1'b1;
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  assign out_vld = (cnt_q != '0);
  assign out_quo = quo_mem[rd_ptr_q];
  assign out_rem = rem_mem[rd_ptr_q];
  assign out_tag = tag_mem[rd_ptr_q];
  assign out_dz  = dz_mem[rd_ptr_q];
  assign err     = err_q;
endmodule

// File: tb/tb_div_sign_ctrl.sv
// Bench for div_sign_ctrl: fixed-latency divider model, arithmetic reference model,
// scoreboard of expected results and issued magnitudes, directed and random stimulus.
module tb_div_sign_ctrl;
  localparam int XLEN  = 32;
  localparam int LAT   = 4;
  localparam int TAGW  = 4;
  localparam int DEPTH = 8;
  localparam int W     = 2*XLEN + TAGW + 1;

  logic            clk, rst;
  logic            in_vld, in_rdy, in_signed;
  logic [XLEN-1:0] in_a, in_b;
  logic [TAGW-1:0] in_tag;
  logic            div_vld, div_ack;
  logic [XLEN-1:0] div_a, div_b, div_quo, div_rem;
  logic            out_vld, out_rdy, out_dz, err;
  logic [XLEN-1:0] out_quo, out_rem;
  logic [TAGW-1:0] out_tag;

  div_sign_ctrl #(.XLEN(XLEN), .LATENCY(LAT), .TAGW(TAGW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .in_tag(in_tag),
    .div_vld(div_vld), .div_a(div_a), .div_b(div_b),
    .div_quo(div_quo), .div_rem(div_rem), .div_ack(div_ack),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_quo(out_quo), .out_rem(out_rem),
    .out_tag(out_tag), .out_dz(out_dz), .err(err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic drop_ack    = 1'b0;
  logic err_allowed = 1'b0;
  logic rand_rdy    = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- divider model: samples div_vld, answers LAT edges later -------------
  logic [2*XLEN:0] dpipe [LAT+1];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= LAT; i++) dpipe[i] <= '0;
    end else begin
      dpipe[0] <= {div_vld,
                   (div_b == 0) ? {XLEN{1'b1}} : div_a / div_b,
                   (div_b == 0) ? div_a : div_a % div_b};
      for (int i = 1; i <= LAT; i++) dpipe[i] <= dpipe[i-1];
    end
  end
  assign div_ack = dpipe[LAT][2*XLEN] & ~drop_ack;
  assign div_quo = dpipe[LAT][2*XLEN-1:XLEN];
  assign div_rem = dpipe[LAT][XLEN-1:0];

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                         input logic s, input logic [TAGW-1:0] tag);
    longint sa, sb, q, r;
    if (b == 0) return {{XLEN{1'b1}}, a, tag, 1'b1};
    sa = s ? {{32{a[31]}}, a} : {32'b0, a};
    sb = s ? {{32{b[31]}}, b} : {32'b0, b};
    q = sa / sb;
    r = sa % sb;
    return {q[31:0], r[31:0], tag, 1'b0};
  endfunction

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic s);
    return (s && x[XLEN-1]) ? (0 - x) : x;
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0]      exp_q[$];
  logic [2*XLEN-1:0] iss_q[$];

  always @(posedge clk) begin
    if (!rst) begin
      if (in_vld && in_rdy) begin
        exp_q.push_back(model(in_a, in_b, in_signed, in_tag));
        iss_q.push_back({mag(in_a, in_signed), mag(in_b, in_signed)});
      end
      if (out_vld && out_rdy && exp_q.size() != 0) void'(exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (div_vld) begin
        if (iss_q.size() == 0) chk("issue_unexpected", 1, 0);
        else chk("issue_mag", {div_a, div_b}, iss_q.pop_front());
      end
      if (out_vld) begin
        if (exp_q.size() == 0) chk("result_unexpected", 1, 0);
        else chk("result", {out_quo, out_rem, out_tag, out_dz}, exp_q[0]);
      end
      if (!err_allowed) chk("err_clear", err, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic s, input logic [TAGW-1:0] tag);
    int n = 0;
    @(negedge clk);
    in_vld = 1'b1; in_a = a; in_b = b; in_signed = s; in_tag = tag;
    while (!in_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("accept_timeout", 1, 0);
  endtask

  task automatic single(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic s,
                        input logic [TAGW-1:0] tag, input logic [XLEN-1:0] eq,
                        input logic [XLEN-1:0] er, input logic edz);
    int lat = 0;
    do_op(a, b, s, tag);
    @(negedge clk);
    in_vld = 1'b0;
    while (!out_vld && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("dir_latency", lat, LAT + 2);
    chk("dir_quo", out_quo, eq);
    chk("dir_rem", out_rem, er);
    chk("dir_dz", out_dz, edz);
    chk("dir_tag", out_tag, tag);
    @(negedge clk);
    chk("dir_popped", out_vld, 0);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_vld) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", n >= 2000, 0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_div_vld"}, div_vld, 0);
    chk({tag, "_div_ab"}, {div_a, div_b}, 0);
    chk({tag, "_out_vld"}, out_vld, 0);
    chk({tag, "_out_data"}, {out_quo, out_rem, out_tag, out_dz}, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_in_rdy"}, in_rdy, 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    in_vld = 1'b0;
    #2 rst = 1'b1;
    exp_q.delete();
    iss_q.delete();
    @(negedge clk);
    check_reset_state("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("post_rst");
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rand_rdy) out_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- main stimulus ----------------
  initial begin
    int acc;
    logic [XLEN-1:0] ra, rb;
    rst = 1'b1; in_vld = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; in_tag = '0;
    out_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("in_rst");
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("after_rst");
    out_rdy = 1'b1;

    single(32'hFFFF_FFFF, 32'h10, 1'b0, 4'h1, 32'h0FFF_FFFF, 32'hF, 1'b0);
    single(32'hFFFF_FFF9, 32'h2, 1'b1, 4'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    single(32'h7, 32'hFFFF_FFFE, 1'b1, 4'h3, 32'hFFFF_FFFD, 32'h1, 1'b0);
    single(32'h1234_5678, 32'h0, 1'b1, 4'h4, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    single(32'h1234_5678, 32'h0, 1'b0, 4'h5, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    single(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 4'h6, 32'h8000_0000, 32'h0, 1'b0);
    single(32'hFFFF_FFF9, 32'h2, 1'b0, 4'h7, 32'h7FFF_FFFC, 32'h1, 1'b0);

    // Backpressure: no pops, continuous offers.
    out_rdy = 1'b0;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_vld = 1'b1; in_a = 32'(i * 1000 + 7); in_b = 32'(i + 1);
      in_signed = i[0]; in_tag = TAGW'(i);
      if (in_rdy) acc++;
    end
    @(negedge clk);
    in_vld = 1'b0;
    chk("bp_accepts", acc, DEPTH);
    chk("bp_in_rdy_low", in_rdy, 0);
    chk("bp_out_vld", out_vld, 1);
    out_rdy = 1'b1;
    @(negedge clk);
    chk("bp_in_rdy_back", in_rdy, 1);
    drain();

    // Random traffic with random backpressure and a mid-stream reset.
    rand_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (i == 100) pulse_reset();
      case ($urandom_range(0, 4))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 20));
        3:       rb = 32'h0 - 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      ra = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        in_vld = 1'b0;
      end
      do_op(ra, rb, 1'($urandom_range(0, 1)), TAGW'(i));
    end
    @(negedge clk);
    in_vld = 1'b0;
    rand_rdy = 1'b0;
    out_rdy = 1'b1;
    drain();
    chk("rand_exp_empty", exp_q.size(), 0);
    chk("rand_iss_empty", iss_q.size(), 0);

    // Missing acknowledge: result still delivered, err sticks until reset.
    err_allowed = 1'b1;
    drop_ack = 1'b1;
    do_op(32'd100, 32'd7, 1'b0, 4'hA);
    @(negedge clk);
    in_vld = 1'b0;
    acc = 0;
    while (!out_vld && acc < 50) begin
      @(negedge clk);
      acc++;
    end
    chk("noack_written", out_vld, 1);
    chk("noack_err", err, 1);
    drop_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("noack_err_sticky", err, 1);
    pulse_reset();
    err_allowed = 1'b0;
    single(32'd100, 32'd7, 1'b0, 4'hB, 32'd14, 32'd2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
